lzc_pipe: RTL and testbench



---
 rtl/fp_pkg.sv | 29 ++
 rtl/lzc_node.sv | 28 ++
 rtl/lzc_pipe.sv | 133 +++++++++++++
 tb/tb_lzc_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and elaboration helpers for the FP add/sub normalisation path.
// Purely compile-time content: no logic, no latency.
// No flow control lives here; the users of these definitions own their handshakes.
package fp_pkg;

  // Per-transaction counting mode of the leading-count unit.
  typedef enum logic {
    LZC_ZEROS = 1'b0,
    LZC_ONES  = 1'b1
  } lzc_mode_e;

  // Width of a leading count for an operand of the given width.
  function automatic int lzc_zw(input int width);
    return $clog2(width);
  endfunction

  // True when some pipeline stage k in 1..stages registers the output of
  // tree level lvl. Stage k sits after level ceil(k*levels/stages).
  // Stages never outnumber levels, so no two stages share a level.
  function automatic bit lzc_stage_at(input int lvl, input int levels, input int stages);
    bit hit;
    hit = 1'b0;
    for (int k = 1; k <= stages; k++) begin
      if ((k * levels + stages - 1) / stages == lvl) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/lzc_node.sv
// One merge node of the leading-count tree: combines a left (more significant) and right child.
// Latency: 0 cycles, purely combinational.
// No flow control; the enclosing pipeline carries valid/ready around the tree.
module lzc_node #(
  parameter int CZW = 0   // count width of each child; 0 means the children are raw operand bits
) (
  input  logic [CZW:0]   left_i,   // {v, z} of the upper half, v in the MSB
  input  logic [CZW:0]   right_i,  // {v, z} of the lower half, v in the MSB
  output logic [CZW+1:0] node_o    // {v, z} of the merged span
);

  logic vl;
  logic vr;

  assign vl = left_i[CZW];
  assign vr = right_i[CZW];

  if (CZW == 0) begin : g_leaf
    // 2-bit leaf: count is 0 if the upper bit is set, else 1.
    assign node_o = {vl | vr, ~vl};
  end else begin : g_merge
    // If the upper half holds a one, its count stands; otherwise the whole
    // upper half is leading and the lower half's count is offset by it.
    assign node_o = {vl | vr,
                     vl ? {1'b0, left_i[CZW-1:0]} : {1'b1, right_i[CZW-1:0]}};
  end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading-zero / leading-one counter with sideband tag, for the FP normalisation path.
// Latency: STAGES cycles (0 = combinational); one result per cycle while out_ready is high.
// Backpressure: per-stage valid/ready with bubble collapse; a held output keeps its data stable.
module lzc_pipe
  import fp_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  parameter  int TAG_W  = 4,
  localparam int ZW     = lzc_zw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ZW-1:0]    out_z,
  output logic             out_v,
  output logic [TAG_W-1:0] out_tag
);

  lzc_mode_e        mode;
  logic [WIDTH-1:0] x;

  // Leading-one counting is leading-zero counting of the inverted operand.
  assign mode = lzc_mode_e'(in_mode);
  assign x    = (mode == LZC_ONES) ? ~in_a : in_a;

  // Level j of the tree has WIDTH>>j nodes, each packed as {v, z[j-1:0]}
  // (j+1 bits), node i at bits [i*(j+1) +: j+1]. Level 0 is the operand
  // itself with each bit acting as a 1-bit node whose v is the bit.
  // Every level exposes dat/vld/tag downstream and up_rdy upstream; a
  // level that is a stage boundary registers them, otherwise they pass
  // straight through.
  for (genvar j = 0; j <= ZW; j++) begin : g_lvl
    localparam int NN = WIDTH >> j;
    localparam int NW = j + 1;

    logic [NN*NW-1:0] dat;     // level output (after register if present)
    logic             vld;     // transaction present at this level's output
    logic [TAG_W-1:0] tag;
    logic             rdy;     // consumer of this level accepts this cycle
    logic             up_rdy;  // this level accepts from the level above

    if (j == ZW) begin : g_tail
      assign rdy = out_ready;
    end else begin : g_body
      assign rdy = g_lvl[j+1].up_rdy;
    end

    if (j == 0) begin : g_src
      assign dat    = x;
      assign vld    = in_valid;
      assign tag    = in_tag;
      assign up_rdy = rdy;
    end else begin : g_tree
      logic [NN*NW-1:0] cdat;
      logic             up_vld;
      logic [TAG_W-1:0] up_tag;

      assign up_vld = g_lvl[j-1].vld;
      assign up_tag = g_lvl[j-1].tag;

      for (genvar i = 0; i < NN; i++) begin : g_node
        lzc_node #(
          .CZW (j - 1)
        ) u_node (
          .left_i  (g_lvl[j-1].dat[(2*i+1)*j +: j]),
          .right_i (g_lvl[j-1].dat[(2*i)*j   +: j]),
          .node_o  (cdat[i*NW +: NW])
        );
      end

      if (lzc_stage_at(j, ZW, STAGES)) begin : g_reg
        logic             vld_q, vld_d;
        logic [NN*NW-1:0] dat_q, dat_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        logic             load;

        // Accept when empty or when the held entry leaves this cycle,
        // so an empty stage never waits on a stalled tail.
        assign up_rdy = !vld_q || rdy;
        assign load   = up_vld && up_rdy;

        // Next state: refill or drain on acceptance, otherwise hold.
        always_comb begin
          vld_d = vld_q;
          dat_d = dat_q;
          tag_d = tag_q;
          if (up_rdy) vld_d = up_vld;
          if (load) begin
            dat_d = cdat;
            tag_d = up_tag;
          end
        end

        // Stage register; reset discards anything in flight.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            tag_q <= '0;
          end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            tag_q <= tag_d;
          end
        end

        assign dat = dat_q;
        assign vld = vld_q;
        assign tag = tag_q;
      end else begin : g_comb
        assign dat    = cdat;
        assign vld    = up_vld;
        assign tag    = up_tag;
        assign up_rdy = rdy;
      end
    end
  end

  // The raw tree count is all-ones for an all-zero operand; report 0 instead.
  assign in_ready  = g_lvl[0].up_rdy;
  assign out_valid = g_lvl[ZW].vld;
  assign out_v     = g_lvl[ZW].dat[ZW];
  assign out_z     = out_v ? g_lvl[ZW].dat[ZW-1:0] : '0;
  assign out_tag   = g_lvl[ZW].tag;

endmodule

// File: tb/tb_lzc_pipe.sv
// Self-checking bench for lzc_pipe: directed 32-bit/2-stage tests, exhaustive 8-bit
// (0 and 3 stages) and a long random 128-bit/3-stage run against a behavioural model.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_lzc_pipe;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 32-bit, 2 stages
  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_v;
  logic [31:0] a_in_a;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [4:0]  a_out_z;
  // DUT B: 8-bit, 3 stages
  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_v;
  logic [7:0]  b_in_a;
  logic [8:0]  b_in_tag, b_out_tag;
  logic [2:0]  b_out_z;
  // DUT C: 8-bit, combinational
  logic        c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready, c_out_v;
  logic [7:0]  c_in_a;
  logic [3:0]  c_in_tag, c_out_tag;
  logic [2:0]  c_out_z;
  // DUT D: 128-bit, 3 stages
  logic         d_in_valid, d_in_ready, d_in_mode, d_out_valid, d_out_ready, d_out_v;
  logic [127:0] d_in_a;
  logic [15:0]  d_in_tag, d_out_tag;
  logic [6:0]   d_out_z;

  lzc_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_a(a_in_a),
    .in_mode(a_in_mode), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_z(a_out_z), .out_v(a_out_v), .out_tag(a_out_tag));

  lzc_pipe #(.WIDTH(8), .STAGES(3), .TAG_W(9)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a),
    .in_mode(b_in_mode), .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_z(b_out_z), .out_v(b_out_v), .out_tag(b_out_tag));

  lzc_pipe #(.WIDTH(8), .STAGES(0), .TAG_W(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_a(c_in_a),
    .in_mode(c_in_mode), .in_tag(c_in_tag), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_z(c_out_z), .out_v(c_out_v), .out_tag(c_out_tag));

  lzc_pipe #(.WIDTH(128), .STAGES(3), .TAG_W(16)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_a(d_in_a),
    .in_mode(d_in_mode), .in_tag(d_in_tag), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_z(d_out_z), .out_v(d_out_v), .out_tag(d_out_tag));

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Number of leading zeros of the effective operand; w when it is all zero.
  function automatic int ref_lead(input logic [127:0] a, input int w, input logic md);
    for (int i = w - 1; i >= 0; i--) begin
      if ((a[i] ^ md) == 1'b1) return w - 1 - i;
    end
    return w;
  endfunction

  // Expected {v, z} packed as v at bit 8, z in bits 7:0.
  function automatic logic [31:0] exp_vz(input logic [127:0] a, input int w, input logic md);
    int n;
    n = ref_lead(a, w, md);
    return (n < w) ? {23'd0, 1'b1, 8'(n)} : 32'd0;
  endfunction

  function automatic logic [31:0] pack_vz(input logic v, input logic [7:0] z);
    return {23'd0, v, z};
  endfunction

  // One isolated transaction on A with out_ready high; checks result and latency.
  task automatic a_one(input logic [31:0] av, input logic md, input logic [3:0] tg,
                       input logic ev, input int ez);
    int cyc;
    a_in_a = av; a_in_mode = md; a_in_tag = tg; a_in_valid = 1'b1;
    @(negedge clk);
    check_eq("a_in_ready", 32'(a_in_ready), 32'd1);
    check_eq("a_no_comb_path", 32'(a_out_valid), 32'd0);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!a_out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("a_latency", 32'(cyc), 32'd2);
    check_eq("a_vz", pack_vz(a_out_v, 8'(a_out_z)), {23'd0, ev, 8'(ez)});
    check_eq("a_tag", 32'(a_out_tag), 32'(tg));
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_a [8];
  logic        bp_m [8];
  int   expq [$];

  initial begin
    int sent, got, occ;
    bit in_hs, out_hs, stall_p, saw_full, load;
    logic [31:0] held_vz;
    logic [3:0]  held_tag;
    logic [127:0] r;

    n_chk = 0; n_fail = 0;
    a_in_valid = 0; a_in_a = '0; a_in_mode = 0; a_in_tag = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_a = '0; b_in_mode = 0; b_in_tag = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_a = '0; c_in_mode = 0; c_in_tag = '0; c_out_ready = 1;
    d_in_valid = 0; d_in_a = '0; d_in_mode = 0; d_in_tag = '0; d_out_ready = 1;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_vz", pack_vz(a_out_v, 8'(a_out_z)), 32'd0);
    check_eq("rst_tag", 32'(a_out_tag), 32'd0);
    check_eq("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed values from the datasheet examples.
    a_one(32'h0000_0001, 1'b0, 4'h1, 1'b1, 31);
    a_one(32'h8000_0000, 1'b0, 4'h2, 1'b1, 0);
    a_one(32'h0000_0000, 1'b0, 4'h3, 1'b0, 0);
    a_one(32'hFFFF_FFFF, 1'b1, 4'h4, 1'b0, 0);
    a_one(32'hFFF0_0000, 1'b1, 4'h5, 1'b1, 12);
    a_one(32'h0001_8000, 1'b0, 4'h6, 1'b1, 15);

    // Backpressure: 8 tagged inputs, out_ready low for cycles 3..6.
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = $urandom >> $urandom_range(31, 0);
      bp_m[i] = 1'($urandom_range(1, 0));
    end
    sent = 0; got = 0; occ = 0; stall_p = 0; saw_full = 0;
    held_vz = '0; held_tag = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      a_out_ready = !(c >= 3 && c <= 6);
      a_in_valid  = (sent < 8);
      if (sent < 8) begin
        a_in_a = bp_a[sent]; a_in_mode = bp_m[sent]; a_in_tag = sent[3:0];
      end
      @(negedge clk);
      check_eq("bp_in_ready", 32'(a_in_ready), 32'((occ < 2) || a_out_ready));
      if (!a_in_ready) saw_full = 1;
      if (stall_p) begin
        check_eq("bp_stall_valid", 32'(a_out_valid), 32'd1);
        check_eq("bp_stall_vz", pack_vz(a_out_v, 8'(a_out_z)), held_vz);
        check_eq("bp_stall_tag", 32'(a_out_tag), 32'(held_tag));
      end
      in_hs  = a_in_valid && a_in_ready;
      out_hs = a_out_valid && a_out_ready;
      if (out_hs) begin
        check_eq("bp_order", 32'(a_out_tag), 32'(got[3:0]));
        check_eq("bp_vz", pack_vz(a_out_v, 8'(a_out_z)), exp_vz(128'(bp_a[got]), 32, bp_m[got]));
        got++;
      end
      stall_p  = a_out_valid && !a_out_ready;
      held_vz  = pack_vz(a_out_v, 8'(a_out_z));
      held_tag = a_out_tag;
      if (in_hs) sent++;
      occ = occ + int'(in_hs) - int'(out_hs);
      @(posedge clk); #1;
    end
    a_in_valid = 0; a_out_ready = 1;
    check_eq("bp_count", 32'(got), 32'd8);
    check_eq("bp_full_seen", 32'(saw_full), 32'd1);

    // Reset with two transactions in flight.
    a_out_ready = 0;
    a_in_valid = 1; a_in_a = 32'h0000_0001; a_in_mode = 0; a_in_tag = 4'hA;
    @(posedge clk); #1;
    a_in_a = 32'h0000_0100; a_in_tag = 4'hB;
    @(posedge clk); #1;
    a_in_valid = 0;
    check_eq("rst_pre_valid", 32'(a_out_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    check_eq("rst_async_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_async_vz", pack_vz(a_out_v, 8'(a_out_z)), 32'd0);
    check_eq("rst_async_tag", 32'(a_out_tag), 32'd0);
    @(posedge clk); #1 rst_n = 1; a_out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_no_output", 32'(a_out_valid), 32'd0);
    end
    check_eq("rst_post_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk); #1;

    // Exhaustive combinational instance.
    for (int i = 0; i < 512; i++) begin
      c_in_a = i[7:0]; c_in_mode = i[8];
      c_in_valid = i[0] ^ i[3]; c_out_ready = i[1]; c_in_tag = i[5:2];
      #1;
      check_eq("c_vz", pack_vz(c_out_v, 8'(c_out_z)), exp_vz(128'(i[7:0]), 8, i[8]));
      check_eq("c_pass", {26'd0, c_out_valid, c_in_ready, c_out_tag},
               {26'd0, i[0] ^ i[3], i[1], i[5:2]});
    end

    // Exhaustive 3-stage 8-bit instance, random backpressure.
    sent = 0; got = 0;
    for (int c = 0; c < 5000 && got < 512; c++) begin
      b_out_ready = ($urandom_range(3, 0) != 0);
      b_in_valid  = (sent < 512);
      if (sent < 512) begin
        b_in_a = sent[7:0]; b_in_mode = sent[8]; b_in_tag = sent[8:0];
      end
      @(negedge clk);
      in_hs = b_in_valid && b_in_ready;
      if (b_out_valid && b_out_ready) begin
        check_eq("b_order", 32'(b_out_tag), 32'(got[8:0]));
        check_eq("b_vz", pack_vz(b_out_v, 8'(b_out_z)), exp_vz(128'(got[7:0]), 8, got[8]));
        got++;
      end
      if (in_hs) sent++;
      @(posedge clk); #1;
    end
    b_in_valid = 0;
    check_eq("b_count", 32'(got), 32'd512);

    // Random 128-bit instance against a scoreboard queue.
    sent = 0; got = 0; load = 1; expq.delete();
    for (int c = 0; c < 40000 && got < 10000; c++) begin
      d_out_ready = 1'($urandom_range(1, 0));
      d_in_valid  = (sent < 10000);
      if (load && sent < 10000) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        d_in_a = r >> $urandom_range(128, 0);
        d_in_mode = 1'($urandom_range(1, 0));
        d_in_tag = sent[15:0];
        load = 0;
      end
      @(negedge clk);
      if (d_out_valid && d_out_ready) begin
        check_eq("d_order", 32'(d_out_tag), 32'(got[15:0]));
        if (expq.size() == 0) check_eq("d_unexpected", 32'd1, 32'd0);
        else check_eq("d_vz", pack_vz(d_out_v, 8'(d_out_z)), 32'(expq.pop_front()));
        got++;
      end
      if (d_in_valid && d_in_ready) begin
        expq.push_back(int'(exp_vz(d_in_a, 128, d_in_mode)));
        sent++;
        load = 1;
      end
      @(posedge clk); #1;
    end
    d_in_valid = 0;
    check_eq("d_count", 32'(got), 32'd10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
